// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes, opcode/funct
// constants, ALU control values and datapath select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU-op class handed from the FSM to the ALU decoder
  typedef enum logic [2:0] {
    AOP_AND   = 3'd0,
    AOP_ADD   = 3'd1,
    AOP_SUB   = 3'd2,
    AOP_SLT   = 3'd3,
    AOP_FUNCT = 3'd4
  } alu_op_t;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

  // R-type funct codes that execute through R_EXEC (jr is handled separately)
  function automatic logic is_alu_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's ALU-op class (and funct, for R-type) onto the 3-bit ALU control code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (alu_op)
      AOP_ADD: alu_ctrl = ALU_ADD;
      AOP_SUB: alu_ctrl = ALU_SUB;
      AOP_SLT: alu_ctrl = ALU_SLT;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: one microstep per clock, driving every datapath
// enable and mux select from the current state and the IR opcode/funct fields.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst,
  input  logic               zero,
  output logic               PCen,
  output logic               LorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUCtrl,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [STATE_W-1:0] state
);

  state_t     state_reg;
  state_t     state_next;
  alu_op_t    alu_op;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_inst;

  assign opcode      = inst[31:26];
  assign funct       = inst[5:0];
  assign unused_inst = ^inst[25:6];
  assign state       = STATE_W'(state_reg);

  mc_alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (ALUCtrl)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    PCen       = 1'b0;
    LorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    alu_op     = AOP_AND;
    PCSrc      = PCSRC_ALU;
    RegDst     = REGDST_RT;

    case (state_reg)
      S_FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        alu_op     = AOP_ADD;
        PCen       = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BRANCH;
        alu_op  = AOP_ADD;
        case (opcode)
          OP_LW, OP_SW:             state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_next = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI: state_next = S_I_EXEC;
          OP_J:                     state_next = S_JUMP;
          OP_RTYPE: begin
            if (funct == FN_JR)          state_next = S_JR;
            else if (is_alu_funct(funct)) state_next = S_R_EXEC;
            else                          state_next = S_FETCH;
          end
          OP_JAL: begin
            // Link in the decode cycle: ALUOut still holds PC+4 from FETCH
            RegWrite   = 1'b1;
            RegDst     = REGDST_RA;
            PCSrc      = PCSRC_JUMP;
            PCen       = 1'b1;
            state_next = S_FETCH;
          end
          default:                  state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = AOP_ADD;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead    = 1'b1;
        LorD       = 1'b1;
        state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        LorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA    = 1'b1;
        alu_op     = AOP_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_SLTI: alu_op = AOP_SLT;
          OP_ANDI: alu_op = AOP_AND;
          default: alu_op = AOP_ADD;
        endcase
        state_next = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = AOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCen    = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        PCen  = 1'b1;
      end
      S_JR: begin
        PCSrc = PCSRC_REG;
        PCen  = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset quiesces the datapath so no in-flight instruction can write
    if (rst) begin
      PCen     = 1'b0;
      LorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_REG;
      alu_op   = AOP_AND;
      PCSrc    = PCSRC_ALU;
      RegDst   = REGDST_RT;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class through its
// state sequence and compares the full control word in every microstep.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        zero;
  logic        PCen, LorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc, RegDst;
  logic [2:0]  ALUCtrl;
  logic [3:0]  state;
  logic [16:0] cw;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
                         S_I_EXEC = 4'd8, S_I_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_JR = 4'd12;

  // Control word: PCen LorD MemRead MemWrite IRWrite MemToReg RegWrite ALUSrcA | SrcB | ALUCtrl | PCSrc | RegDst
  localparam logic [16:0] CW_FETCH   = 17'b10101000_01_010_00_00;
  localparam logic [16:0] CW_DECODE  = 17'b00000000_11_010_00_00;
  localparam logic [16:0] CW_JAL     = 17'b10000010_11_010_01_10;
  localparam logic [16:0] CW_MADDR   = 17'b00000001_10_010_00_00;
  localparam logic [16:0] CW_MRD     = 17'b01100000_00_000_00_00;
  localparam logic [16:0] CW_MWB     = 17'b00000110_00_000_00_00;
  localparam logic [16:0] CW_MWR     = 17'b01010000_00_000_00_00;
  localparam logic [16:0] CW_RSUB    = 17'b00000001_00_110_00_00;
  localparam logic [16:0] CW_RWB     = 17'b00000010_00_000_00_01;
  localparam logic [16:0] CW_IADD    = 17'b00000001_10_010_00_00;
  localparam logic [16:0] CW_IWB     = 17'b00000010_00_000_00_00;
  localparam logic [16:0] CW_BR_TAKE = 17'b10000001_00_110_10_00;
  localparam logic [16:0] CW_BR_NOT  = 17'b00000001_00_110_10_00;
  localparam logic [16:0] CW_JUMP    = 17'b10000000_00_000_01_00;
  localparam logic [16:0] CW_JR      = 17'b10000000_00_000_11_00;

  assign cw = {PCen, LorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUCtrl, PCSrc, RegDst};

  always #5 clk = ~clk;

  mc_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .inst(inst), .zero(zero),
    .PCen(PCen), .LorD(LorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .PCSrc(PCSrc), .RegDst(RegDst), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst = 32'h0; zero = 1'b0;
    tick();
    tick();
    tests++;
    if (state !== S_FETCH || cw !== 17'b0) begin
      fails++;
      $display("FAIL reset_hold state=%0d cw=%b, expected state=%0d cw=%b", state, cw, S_FETCH, 17'b0);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (state !== S_FETCH || cw !== CW_FETCH) begin
      fails++;
      $display("FAIL reset_release state=%0d cw=%b, expected state=%0d cw=%b", state, cw, S_FETCH, CW_FETCH);
    end
    $display("[TB] reset: state=%0d cw=%b", state, cw);
  endtask

  task automatic test_lw();
    logic [3:0]  exp_st [6] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_FETCH};
    logic [16:0] exp_cw [6] = '{CW_FETCH, CW_DECODE, CW_MADDR, CW_MRD, CW_MWB, CW_FETCH};
    inst = 32'h8C880004;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (state !== exp_st[i] || cw !== exp_cw[i]) begin
        fails++;
        $display("FAIL lw_step%0d state=%0d cw=%b, expected state=%0d cw=%b", i, state, cw, exp_st[i], exp_cw[i]);
      end
      if (i < 5) tick();
    end
    $display("[TB] lw 0x%08h done", inst);
  endtask

  task automatic test_sw_addi();
    logic [3:0]  exp_st [9] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR,
                                S_FETCH, S_DECODE, S_I_EXEC, S_I_WB, S_FETCH};
    logic [16:0] exp_cw [9] = '{CW_FETCH, CW_DECODE, CW_MADDR, CW_MWR,
                                CW_FETCH, CW_DECODE, CW_IADD, CW_IWB, CW_FETCH};
    inst = 32'hAC880004;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) inst = 32'h21090005;
      #1;
      tests++;
      if (state !== exp_st[i] || cw !== exp_cw[i]) begin
        fails++;
        $display("FAIL sw_addi_step%0d state=%0d cw=%b, expected state=%0d cw=%b", i, state, cw, exp_st[i], exp_cw[i]);
      end
      if (MemRead === 1'b1 && MemWrite === 1'b1) begin
        fails++;
        $display("FAIL mem_excl_step%0d MemRead=%b MemWrite=%b, expected not both 1", i, MemRead, MemWrite);
      end
      if (i < 8) tick();
    end
    $display("[TB] sw then addi done");
  endtask

  task automatic test_rtype_sub();
    logic [3:0]  exp_st [5] = '{S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_FETCH};
    logic [16:0] exp_cw [5] = '{CW_FETCH, CW_DECODE, CW_RSUB, CW_RWB, CW_FETCH};
    inst = 32'h01095022;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (state !== exp_st[i] || cw !== exp_cw[i]) begin
        fails++;
        $display("FAIL sub_step%0d state=%0d cw=%b, expected state=%0d cw=%b", i, state, cw, exp_st[i], exp_cw[i]);
      end
      if (i < 4) tick();
    end
    $display("[TB] sub 0x%08h done", inst);
  endtask

  task automatic test_branch();
    logic [31:0] br_inst [4] = '{32'h11090003, 32'h11090003, 32'h15090003, 32'h15090003};
    logic        br_zero [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [16:0] br_cw   [4] = '{CW_BR_TAKE, CW_BR_NOT, CW_BR_TAKE, CW_BR_NOT};
    for (int k = 0; k < 4; k++) begin
      inst = br_inst[k];
      zero = br_zero[k];
      tick();
      tick();
      tests++;
      if (state !== S_BRANCH || cw !== br_cw[k]) begin
        fails++;
        $display("FAIL branch%0d state=%0d cw=%b, expected state=%0d cw=%b", k, state, cw, S_BRANCH, br_cw[k]);
      end
      tick();
      tests++;
      if (state !== S_FETCH) begin
        fails++;
        $display("FAIL branch%0d_ret state=%0d, expected %0d", k, state, S_FETCH);
      end
      $display("[TB] branch inst=0x%08h zero=%b PCen=%b", inst, zero, br_cw[k][16]);
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [31:0] j_inst [3] = '{32'h0C000010, 32'h03E00008, 32'h08000010};
    logic [3:0]  j_st   [3] = '{S_DECODE, S_JR, S_JUMP};
    logic [16:0] j_cw   [3] = '{CW_JAL, CW_JR, CW_JUMP};
    int          j_wait [3] = '{1, 2, 2};
    for (int k = 0; k < 3; k++) begin
      inst = j_inst[k];
      for (int c = 0; c < j_wait[k]; c++) tick();
      tests++;
      if (state !== j_st[k] || cw !== j_cw[k]) begin
        fails++;
        $display("FAIL jump%0d state=%0d cw=%b, expected state=%0d cw=%b", k, state, cw, j_st[k], j_cw[k]);
      end
      tick();
      tests++;
      if (state !== S_FETCH) begin
        fails++;
        $display("FAIL jump%0d_ret state=%0d, expected %0d", k, state, S_FETCH);
      end
      $display("[TB] jump inst=0x%08h cw=%b", inst, j_cw[k]);
    end
  endtask

  task automatic test_undefined();
    inst = 32'hFC000000;
    tick();
    tests++;
    if (state !== S_DECODE || cw !== CW_DECODE) begin
      fails++;
      $display("FAIL undef_decode state=%0d cw=%b, expected state=%0d cw=%b", state, cw, S_DECODE, CW_DECODE);
    end
    tick();
    tests++;
    if (state !== S_FETCH) begin
      fails++;
      $display("FAIL undef_ret state=%0d, expected %0d", state, S_FETCH);
    end
    $display("[TB] undefined opcode 0x3F returned to FETCH");
  endtask

  task automatic test_reset_mid();
    inst = 32'h8C880004;
    tick();
    tick();
    tick();
    tests++;
    if (state !== S_MEM_RD) begin
      fails++;
      $display("FAIL mid_pre state=%0d, expected %0d", state, S_MEM_RD);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (cw !== 17'b0) begin
      fails++;
      $display("FAIL mid_rst_outputs cw=%b, expected %b", cw, 17'b0);
    end
    tick();
    tests++;
    if (state !== S_FETCH || RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_fetch state=%0d RegWrite=%b, expected state=%0d RegWrite=0", state, RegWrite, S_FETCH);
    end
    rst = 1'b0;
    inst = 32'hFC000000;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (RegWrite !== 1'b0) begin
        fails++;
        $display("FAIL mid_no_write%0d RegWrite=%b, expected 0", c, RegWrite);
      end
      tick();
    end
    $display("[TB] reset during MEM_RD aborted lw, state=%0d", state);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_addi();
    test_rtype_sub();
    test_branch();
    test_jumps();
    test_undefined();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
